// File: rtl/aes_pkg.sv
// Shared AES tables, state encoding and byte-level helpers for the decryption core.
// State layout: byte 0 = bits [127:120], column-major (column c = 32-bit word c).
package aes_pkg;

  typedef enum logic [3:0] {
    IDLE, KEYEXP, INIT_ARK, ISR_ISB, ARK, IMC0, IMC1, IMC2, IMC3, DONE
  } aes_dec_state_t;

  typedef logic [0:255][7:0] sbox_t;

  localparam sbox_t SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Inverse table is derived at elaboration so it can never disagree with SBOX.
  function automatic sbox_t invert_sbox(input sbox_t s);
    sbox_t r;
    r = '0;
    for (int unsigned i = 0; i < 256; i++) r[s[i]] = 8'(i);
    return r;
  endfunction

  localparam sbox_t INV_SBOX = invert_sbox(SBOX);

  localparam logic [1:10][7:0] RCON = {
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    logic [31:0] o;
    o = '0;
    for (int unsigned k = 0; k < 4; k++) o[8*k +: 8] = SBOX[w[8*k +: 8]];
    return o;
  endfunction

  // Row r rotates right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned c = 0; c < 4; c++)
      for (int unsigned r = 0; r < 4; r++)
        o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + 4 - r) % 4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int unsigned b = 0; b < 16; b++) o[8*b +: 8] = INV_SBOX[s[8*b +: 8]];
    return o;
  endfunction

endpackage

// File: rtl/aes_inv_mix_column.sv
// Combinational InvMixColumns on a single 32-bit column; byte 0 = bits [31:24].
module aes_inv_mix_column
  import aes_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  // Multiples built from x2/x4/x8: 09=8+1, 0b=8+2+1, 0d=8+4+1, 0e=8+4+2.
  always_comb begin
    for (int unsigned k = 0; k < 4; k++) begin
      logic [7:0] x2, x4, x8;
      a[k]  = col_i[31 - 8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    col_o = '0;
    for (int unsigned r = 0; r < 4; r++)
      col_o[31 - 8*r -: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
  end

endmodule

// File: rtl/aes_decrypt_core.sv
// Iterative AES-128 inverse cipher: on-chip key expansion, then one round step per cycle
// with a single InvMixColumn unit shared across four column cycles.
module aes_decrypt_core
  import aes_pkg::*;
#(
  parameter int unsigned NR = 10
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         AES_START,
  input  logic [127:0] AES_KEY,
  input  logic [127:0] AES_MSG_ENC,
  output logic [127:0] AES_MSG_DEC,
  output logic         AES_DONE
);

  if (NR != 10) begin : g_nr_check
    $error("aes_decrypt_core: only NR = 10 (AES-128) is supported");
  end

  typedef logic [0:3][31:0] words_t;

  aes_dec_state_t fsm_q, fsm_d;
  logic [3:0]     cnt_q, cnt_d;
  logic [127:0]   state_q, state_d;
  logic [127:0]   rk_q [0:NR];
  logic [127:0]   rk_d [0:NR];
  logic [127:0]   dec_q, dec_d;
  logic           done_q, done_d;

  logic [1:0]     imc_col;
  logic [31:0]    imc_in, imc_out;
  words_t         state_w;

  assign state_w = state_q;
  assign imc_in  = state_w[imc_col];

  always_comb begin
    unique case (fsm_q)
      IMC1:    imc_col = 2'd1;
      IMC2:    imc_col = 2'd2;
      IMC3:    imc_col = 2'd3;
      default: imc_col = 2'd0;
    endcase
  end

  aes_inv_mix_column u_imc (
    .col_i (imc_in),
    .col_o (imc_out)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      fsm_q   <= IDLE;
      cnt_q   <= '0;
      state_q <= '0;
      rk_q    <= '{default: '0};
      dec_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      rk_q    <= rk_d;
      dec_q   <= dec_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    words_t     kp, kn, cols;
    logic [31:0] t;
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    rk_d    = rk_q;
    dec_d   = dec_q;
    done_d  = done_q;
    kp      = '0;
    kn      = '0;
    t       = '0;
    cols    = state_q;

    unique case (fsm_q)
      IDLE: begin
        if (AES_START) begin
          rk_d[0] = AES_KEY;
          state_d = AES_MSG_ENC;
          cnt_d   = 4'd1;
          fsm_d   = KEYEXP;
        end
      end
      KEYEXP: begin
        kp    = rk_q[cnt_q - 4'd1];
        t     = sub_word(rot_word(kp[3])) ^ {RCON[cnt_q], 24'h0};
        kn[0] = kp[0] ^ t;
        kn[1] = kp[1] ^ kn[0];
        kn[2] = kp[2] ^ kn[1];
        kn[3] = kp[3] ^ kn[2];
        rk_d[cnt_q] = kn;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'(NR)) fsm_d = INIT_ARK;
      end
      INIT_ARK: begin
        state_d = state_q ^ rk_q[NR];
        cnt_d   = 4'(NR - 1);
        fsm_d   = ISR_ISB;
      end
      ISR_ISB: begin
        state_d = inv_sub_bytes(inv_shift_rows(state_q));
        fsm_d   = ARK;
      end
      ARK: begin
        state_d = state_q ^ rk_q[cnt_q];
        if (cnt_q == '0) begin
          dec_d  = state_d;
          done_d = 1'b1;
          fsm_d  = DONE;
        end else begin
          fsm_d = IMC0;
        end
      end
      IMC0, IMC1, IMC2, IMC3: begin
        cols[imc_col] = imc_out;
        state_d = cols;
        if (fsm_q == IMC3) begin
          cnt_d = cnt_q - 4'd1;
          fsm_d = ISR_ISB;
        end else begin
          fsm_d = aes_dec_state_t'(fsm_q + 4'd1);
        end
      end
      DONE: begin
        if (!AES_START) begin
          done_d = 1'b0;
          fsm_d  = IDLE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  assign AES_MSG_DEC = dec_q;
  assign AES_DONE    = done_q;

endmodule

// File: tb/tb_aes_decrypt_core.sv
// Bench for aes_decrypt_core: known-answer vector table, latency checks and control corner cases.
module tb_aes_decrypt_core;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic [127:0] AES_MSG_DEC;
  logic         AES_DONE;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [127:0] exp_q [$];
  logic         done_prev;

  typedef struct {
    logic [127:0] key;
    logic [127:0] enc;
    logic [127:0] dec;
  } vec_t;

  vec_t vecs [4];

  aes_decrypt_core #(.NR(10)) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .AES_START   (AES_START),
    .AES_KEY     (AES_KEY),
    .AES_MSG_ENC (AES_MSG_ENC),
    .AES_MSG_DEC (AES_MSG_DEC),
    .AES_DONE    (AES_DONE)
  );

  initial forever #5 CLK = ~CLK;

  function automatic void check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start(input vec_t v);
    AES_KEY     = v.key;
    AES_MSG_ENC = v.enc;
    AES_START   = 1'b1;
    exp_q.push_back(v.dec);
  endtask

  // Counts edges from the capturing edge until AES_DONE reads 1; optional mid-run input disturbances.
  task automatic wait_done(input string nm, input int lat0, input int chg_edge, input int drop_edge);
    int lat;
    lat = lat0;
    do begin
      tick();
      lat++;
      if (lat == chg_edge) begin
        AES_KEY     = '0;
        AES_MSG_ENC = '0;
      end
      if (lat == drop_edge) AES_START = 1'b0;
    end while (AES_DONE !== 1'b1 && lat < 200);
    check({nm, "_latency"}, 128'(lat), 128'd68);
  endtask

  // Scoreboard: every rising AES_DONE consumes one expected plaintext.
  initial begin
    done_prev = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      if (AES_DONE === 1'b1 && done_prev !== 1'b1) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected_done: got done=1 with no pending request, expected none");
        end else begin
          check("sb_plaintext", AES_MSG_DEC, exp_q.pop_front());
        end
      end
      done_prev = AES_DONE;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0] = '{key: 128'h000102030405060708090a0b0c0d0e0f,
                enc: 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                dec: 128'h00112233445566778899aabbccddeeff};
    vecs[1] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                enc: 128'h3925841d02dc09fbdc118597196a0b32,
                dec: 128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{key: 128'h0,
                enc: 128'h66e94bd4ef8a2c3b884cfa59ca342b2e,
                dec: 128'h0};
    vecs[3] = '{key: 128'h2b7e151628aed2a6abf7158809cf4f3c,
                enc: 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                dec: 128'h6bc1bee22e409f96e93d7e117393172a};

    // Reset held with START asserted: no capture until release.
    RESET = 1'b0;
    start(vecs[0]);
    repeat (3) tick();
    check("rst_done", 128'(AES_DONE), 128'd0);
    check("rst_dec", AES_MSG_DEC, 128'h0);
    RESET = 1'b1;
    wait_done("rst_release", 0, 0, 0);
    tick();
    check("done_hold", 128'(AES_DONE), 128'd1);
    AES_START = 1'b0;
    tick();
    check("done_clear", 128'(AES_DONE), 128'd0);

    for (int i = 0; i < 4; i++) begin
      start(vecs[i]);
      wait_done($sformatf("vec%0d", i), 0, 0, 0);
      repeat (2) tick();
      check($sformatf("vec%0d_done_hold", i), 128'(AES_DONE), 128'd1);
      check($sformatf("vec%0d_dec_hold", i), AES_MSG_DEC, vecs[i].dec);
      AES_START = 1'b0;
      tick();
      check($sformatf("vec%0d_done_clear", i), 128'(AES_DONE), 128'd0);
      tick();
      check($sformatf("vec%0d_dec_persist", i), AES_MSG_DEC, vecs[i].dec);
    end

    // Inputs disturbed mid-run and START dropped early: one-cycle done pulse.
    start(vecs[0]);
    wait_done("disturb", 0, 5, 20);
    tick();
    check("disturb_done_pulse", 128'(AES_DONE), 128'd0);
    check("disturb_dec_persist", AES_MSG_DEC, vecs[0].dec);

    // Reset sampled at edge 30 of a run, then restart.
    AES_KEY     = vecs[1].key;
    AES_MSG_ENC = vecs[1].enc;
    AES_START   = 1'b1;
    repeat (29) tick();
    RESET = 1'b0;
    tick();
    check("midrun_rst_done", 128'(AES_DONE), 128'd0);
    check("midrun_rst_dec", AES_MSG_DEC, 128'h0);
    RESET = 1'b1;
    start(vecs[1]);
    wait_done("midrun_restart", 0, 0, 0);
    AES_START = 1'b0;
    tick();

    // Back-to-back with a single-cycle START low between requests.
    start(vecs[0]);
    wait_done("b2b_first", 0, 0, 0);
    tick();
    check("b2b_done_hold", 128'(AES_DONE), 128'd1);
    AES_START = 1'b0;
    tick();
    check("b2b_done_clear", 128'(AES_DONE), 128'd0);
    start(vecs[1]);
    repeat (10) tick();
    check("b2b_dec_old", AES_MSG_DEC, vecs[0].dec);
    check("b2b_done_low", 128'(AES_DONE), 128'd0);
    wait_done("b2b_second", 10, 0, 0);
    check("b2b_dec_new", AES_MSG_DEC, vecs[1].dec);
    AES_START = 1'b0;
    tick();
    check("sb_drained", 128'(exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
